// File: rtl/mem_responder.sv
// Memory-side responder: arbitrates level-held icache/dcache requests onto one
// word-wide physical memory port and returns data with a one-cycle resp pulse.
module mem_responder #(
  parameter int TIMEOUT    = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] icache_address,
  input  logic        icache_read,
  output logic [31:0] icache_rdata,
  output logic        icache_resp,
  input  logic [31:0] dcache_address,
  input  logic        dcache_read,
  input  logic        dcache_write,
  input  logic [31:0] dcache_wdata,
  input  logic [3:0]  dcache_mbe,
  output logic [31:0] dcache_rdata,
  output logic        dcache_resp,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byte_en,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp,
  output logic        protocol_err,
  output logic        timeout_err,
  output logic [1:0]  fsm_state
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    D_ACC = 2'd1,
    I_ACC = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state;
  logic          skip;
  logic          op_write;
  logic [SW-1:0] starve_cnt;
  logic [TW-1:0] tmo_cnt;

  logic          dc_req;
  logic          ic_wins;
  logic          starved;
  logic          acc_end;
  logic [31:0]   done_data;

  // Handshake: cache requests are level-held until their resp pulse; mem
  // strobes are held until mem_resp (or timeout), and resp lasts one cycle.
  always_comb begin
    dc_req    = dcache_read | dcache_write;
    starved   = (starve_cnt == SW'(STARVE_MAX));
    ic_wins   = icache_read & (~dc_req | starved);
    acc_end   = mem_resp | (tmo_cnt == TW'(TIMEOUT - 1));
    done_data = 32'h0;
    if (!mem_resp) begin
      done_data = TIMEOUT_DATA;
    end else if (!op_write) begin
      done_data = mem_rdata;
    end
  end

  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      skip         <= 1'b0;
      op_write     <= 1'b0;
      starve_cnt   <= '0;
      tmo_cnt      <= '0;
      icache_rdata <= 32'h0;
      icache_resp  <= 1'b0;
      dcache_rdata <= 32'h0;
      dcache_resp  <= 1'b0;
      mem_address  <= 32'h0;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      mem_wdata    <= 32'h0;
      mem_byte_en  <= 4'h0;
      protocol_err <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      icache_resp <= 1'b0;
      dcache_resp <= 1'b0;
      if (dcache_read && dcache_write) begin
        protocol_err <= 1'b1;
      end

      case (state)
        IDLE: begin
          skip <= 1'b0;
          // The cycle after DONE grants nothing: the served initiator is
          // still dropping its request and must not be served twice.
          if (!skip && (dc_req || icache_read)) begin
            tmo_cnt <= '0;
            if (ic_wins) begin
              state       <= I_ACC;
              op_write    <= 1'b0;
              starve_cnt  <= '0;
              mem_address <= {icache_address[31:2], 2'b00};
              mem_read    <= 1'b1;
              mem_write   <= 1'b0;
              mem_wdata   <= 32'h0;
              mem_byte_en <= 4'hF;
            end else begin
              state       <= D_ACC;
              op_write    <= dcache_write;
              mem_address <= {dcache_address[31:2], 2'b00};
              mem_read    <= ~dcache_write;
              mem_write   <= dcache_write;
              mem_wdata   <= dcache_write ? dcache_wdata : 32'h0;
              mem_byte_en <= dcache_write ? dcache_mbe : 4'hF;
              if (icache_read && !starved) begin
                starve_cnt <= starve_cnt + SW'(1);
              end
            end
          end
        end

        D_ACC, I_ACC: begin
          if (acc_end) begin
            state     <= DONE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if (!mem_resp) begin
              timeout_err <= 1'b1;
            end
            if (state == D_ACC) begin
              dcache_rdata <= done_data;
              dcache_resp  <= 1'b1;
            end else begin
              icache_rdata <= done_data;
              icache_resp  <= 1'b1;
            end
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end

        DONE: begin
          state <= IDLE;
          skip  <= 1'b1;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: drivers act as the caches and the physical
// memory; a negedge monitor checks every resp pulse against an expected queue.
module tb_mem_responder;

  logic        clk;
  logic        rst;
  logic [31:0] icache_address;
  logic        icache_read;
  logic [31:0] icache_rdata;
  logic        icache_resp;
  logic [31:0] dcache_address;
  logic        dcache_read;
  logic        dcache_write;
  logic [31:0] dcache_wdata;
  logic [3:0]  dcache_mbe;
  logic [31:0] dcache_rdata;
  logic        dcache_resp;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_en;
  logic [31:0] mem_rdata;
  logic        mem_resp;
  logic        protocol_err;
  logic        timeout_err;
  logic [1:0]  fsm_state;

  mem_responder #(.TIMEOUT(64), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .icache_address(icache_address), .icache_read(icache_read),
    .icache_rdata(icache_rdata), .icache_resp(icache_resp),
    .dcache_address(dcache_address), .dcache_read(dcache_read),
    .dcache_write(dcache_write), .dcache_wdata(dcache_wdata),
    .dcache_mbe(dcache_mbe), .dcache_rdata(dcache_rdata),
    .dcache_resp(dcache_resp),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_byte_en(mem_byte_en),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .protocol_err(protocol_err), .timeout_err(timeout_err),
    .fsm_state(fsm_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int tests = 0;
  int fails = 0;

  // Expected resp entries: bit 32 = dcache port, bits 31:0 = rdata
  logic [32:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (icache_resp || dcache_resp) begin
      logic [32:0] e;
      if (icache_resp && dcache_resp) begin
        check("dual_resp", 32'd1, 32'd0);
      end else if (exp_q.size() == 0) begin
        check("unexpected_resp", {31'd0, dcache_resp}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("resp_port", {31'd0, dcache_resp}, {31'd0, e[32]});
        check("resp_rdata", dcache_resp ? dcache_rdata : icache_rdata, e[31:0]);
      end
    end
  end

  // Drivers
  task automatic wait_strobe(output bit ok);
    int n;
    n = 0;
    while (!(mem_read || mem_write) && n < 20) begin
      tick();
      n++;
    end
    ok = mem_read || mem_write;
    if (!ok) check("strobe_wait_expired", 32'd0, 32'd1);
  endtask

  task automatic serve(input string name, input logic [31:0] addr, input logic wr,
                       input logic [3:0] be, input logic [31:0] wdata,
                       input int delay, input logic [31:0] rdata);
    bit ok;
    wait_strobe(ok);
    if (ok) begin
      check({name, "_addr"}, mem_address, addr);
      check({name, "_read"}, {31'd0, mem_read}, {31'd0, ~wr});
      check({name, "_write"}, {31'd0, mem_write}, {31'd0, wr});
      check({name, "_be"}, {28'd0, mem_byte_en}, {28'd0, be});
      if (wr) check({name, "_wdata"}, mem_wdata, wdata);
      repeat (delay) tick();
      mem_rdata = rdata;
      mem_resp  = 1'b1;
      tick();
      mem_resp  = 1'b0;
      mem_rdata = 32'h0;
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_mem_rw"}, {30'd0, mem_read, mem_write}, 32'd0);
    check({name, "_mem_addr"}, mem_address, 32'd0);
    check({name, "_mem_be"}, {28'd0, mem_byte_en}, 32'd0);
    check({name, "_resps"}, {30'd0, icache_resp, dcache_resp}, 32'd0);
    check({name, "_rdata"}, icache_rdata | dcache_rdata, 32'd0);
    check({name, "_errs"}, {30'd0, protocol_err, timeout_err}, 32'd0);
    check({name, "_state"}, {30'd0, fsm_state}, 32'd0);
  endtask

  initial begin
    bit ok;
    int n;
    int last_cyc;
    logic is_d_seq [10];
    is_d_seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    rst = 1'b0;
    icache_address = 32'h0; icache_read = 1'b0;
    dcache_address = 32'h0; dcache_read = 1'b0; dcache_write = 1'b0;
    dcache_wdata = 32'h0; dcache_mbe = 4'h0;
    mem_rdata = 32'h0; mem_resp = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b1;
    tick();

    // 1: instruction fetch, mem_resp two cycles into the access
    icache_address = 32'h60; icache_read = 1'b1;
    exp_q.push_back({1'b0, 32'h0000_0013});
    serve("t1", 32'h60, 1'b0, 4'hF, 32'h0, 2, 32'h0000_0013);
    icache_read = 1'b0;
    repeat (3) tick();

    // 2: unaligned store, minimum latency (resp two ticks after request)
    dcache_address = 32'h1003; dcache_write = 1'b1;
    dcache_wdata = 32'hAABB_CCDD; dcache_mbe = 4'b1000;
    exp_q.push_back({1'b1, 32'h0});
    n = cyc;
    serve("t2", 32'h1000, 1'b1, 4'b1000, 32'hAABB_CCDD, 0, 32'h5555_5555);
    check("t2_latency", cyc - n, 32'd2);
    check("t2_dresp", {31'd0, dcache_resp}, 32'd1);
    dcache_write = 1'b0;
    repeat (3) tick();

    // 3: both held; grants D,D,D,D,I repeating, one access per 4 cycles
    icache_address = 32'h200; icache_read = 1'b1;
    dcache_address = 32'h300; dcache_read = 1'b1;
    last_cyc = 0;
    for (int i = 0; i < 10; i++) begin
      wait_strobe(ok);
      if (!ok) break;
      check($sformatf("t3_grant%0d", i), mem_address, is_d_seq[i] ? 32'h300 : 32'h200);
      if (i > 0) check($sformatf("t3_spacing%0d", i), cyc - last_cyc, 32'd4);
      last_cyc = cyc;
      exp_q.push_back({is_d_seq[i], 32'h3000_0000 + 32'(i)});
      mem_rdata = 32'h3000_0000 + 32'(i);
      mem_resp = 1'b1;
      tick();
      mem_resp = 1'b0;
      mem_rdata = 32'h0;
    end
    icache_read = 1'b0; dcache_read = 1'b0;
    repeat (4) tick();

    // 4: dcache read never answered -> timeout after 64 access cycles
    dcache_address = 32'h400; dcache_read = 1'b1;
    exp_q.push_back({1'b1, 32'hDEAD_BEEF});
    wait_strobe(ok);
    n = 0;
    while (mem_read && n < 100) begin
      n++;
      tick();
    end
    check("t4_strobe_cycles", n, 32'd64);
    check("t4_timeout_err", {31'd0, timeout_err}, 32'd1);
    dcache_read = 1'b0;
    repeat (10) tick();
    check("t4_timeout_sticky", {31'd0, timeout_err}, 32'd1);

    // 5: reset while in D_ACC; late mem_resp must produce no resp
    dcache_address = 32'h500; dcache_read = 1'b1;
    wait_strobe(ok);
    check("t5_in_dacc", {30'd0, fsm_state}, 32'd1);
    rst = 1'b0; dcache_read = 1'b0;
    tick();
    check_reset_outputs("t5");
    rst = 1'b1;
    mem_rdata = 32'h7777_7777; mem_resp = 1'b1;
    tick();
    mem_resp = 1'b0; mem_rdata = 32'h0;
    repeat (4) tick();
    check("t5_idle", {30'd0, fsm_state}, 32'd0);

    // 6: read and write together -> write performed, protocol_err sticky
    dcache_address = 32'h604; dcache_read = 1'b1; dcache_write = 1'b1;
    dcache_wdata = 32'h1234_5678; dcache_mbe = 4'b0110;
    exp_q.push_back({1'b1, 32'h0});
    serve("t6", 32'h604, 1'b1, 4'b0110, 32'h1234_5678, 1, 32'h9999_9999);
    dcache_read = 1'b0; dcache_write = 1'b0;
    check("t6_protocol_err", {31'd0, protocol_err}, 32'd1);
    repeat (6) tick();
    check("t6_protocol_sticky", {31'd0, protocol_err}, 32'd1);
    rst = 1'b0;
    tick();
    check("t6_protocol_cleared", {31'd0, protocol_err}, 32'd0);
    rst = 1'b1;
    repeat (3) tick();

    check("exp_q_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
